// File: rtl/echo_frame_writer.sv
// Frames ADC echo samples into the sample FIFO: blanking run, marker header, fixed data window.
// Optional macro FRAME_COUNT_EN adds a second header word carrying a 15-bit frame counter.
module echo_frame_writer #(
    parameter int          BLANK_SAMPLES  = 64,
    parameter int          WINDOW_SAMPLES = 1024,
    parameter logic [15:0] HEADER_WORD    = 16'hFFFF
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic        ON,
    input  logic        TX_START,
    input  logic        ADC_FIN,
    input  logic [15:0] ADC_DATA,
    input  logic        FIFO_FULL,
    output logic        FIFO_WR,
    output logic [15:0] FIFO_DATA,
    output logic        BUSY,
    output logic        OVERFLOW,
    output logic        FRAME_DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BLANK   = 3'd1,
        HEADER  = 3'd2,
        HDR_CNT = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] BLANK_N  = 16'(BLANK_SAMPLES);
    localparam logic [15:0] WINDOW_N = 16'(WINDOW_SAMPLES);

    state_t      state, state_n;
    logic        fin_q1, fin_q2;
    logic        sample_edge;
    logic        sample_valid;
    logic [14:0] hold_data;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic        wr_n, done_n, ovf_n;
    logic [15:0] data_n;

    // The scaled word drops the ADC LSB.
    logic unused_lsb;
    assign unused_lsb = ADC_DATA[0];

    assign sample_edge = fin_q1 & ~fin_q2;
    assign cnt_inc     = cnt + 16'd1;
    assign BUSY        = (state != IDLE);

`ifdef FRAME_COUNT_EN
    logic [14:0] frame_cnt;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST)
            frame_cnt <= 15'd0;
        else if (done_n)
            frame_cnt <= frame_cnt + 15'd1;
    end
`endif

    // sample_valid delays the edge by one cycle so the held sample is settled when written.
    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            fin_q1       <= 1'b0;
            fin_q2       <= 1'b0;
            sample_valid <= 1'b0;
            hold_data    <= 15'd0;
            state        <= IDLE;
            cnt          <= 16'd0;
            FIFO_WR      <= 1'b0;
            FIFO_DATA    <= 16'h0000;
            OVERFLOW     <= 1'b0;
            FRAME_DONE   <= 1'b0;
        end else begin
            fin_q1       <= ADC_FIN;
            fin_q2       <= fin_q1;
            sample_valid <= sample_edge;
            if (sample_edge)
                hold_data <= ADC_DATA[15:1];
            state      <= state_n;
            cnt        <= cnt_n;
            FIFO_WR    <= wr_n;
            if (wr_n)
                FIFO_DATA <= data_n;
            OVERFLOW   <= ovf_n;
            FRAME_DONE <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_n    = 1'b0;
        data_n  = 16'h0000;
        done_n  = 1'b0;
        ovf_n   = OVERFLOW;
        if (!ON) begin
            state_n = IDLE;
            ovf_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (TX_START) begin
                        cnt_n   = 16'd0;
                        ovf_n   = 1'b0;
                        state_n = (BLANK_N == 16'd0) ? HEADER : BLANK;
                    end
                end
                BLANK: begin
                    if (sample_valid) begin
                        if (cnt_inc == BLANK_N) begin
                            cnt_n   = 16'd0;
                            state_n = HEADER;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                HEADER: begin
                    if (FIFO_FULL) begin
                        ovf_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        wr_n   = 1'b1;
                        data_n = HEADER_WORD;
`ifdef FRAME_COUNT_EN
                        state_n = HDR_CNT;
`else
                        state_n = CAPTURE;
`endif
                    end
                end
`ifdef FRAME_COUNT_EN
                HDR_CNT: begin
                    if (FIFO_FULL) begin
                        ovf_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        wr_n    = 1'b1;
                        data_n  = {1'b0, frame_cnt};
                        state_n = CAPTURE;
                    end
                end
`endif
                CAPTURE: begin
                    if (sample_valid) begin
                        if (FIFO_FULL) begin
                            ovf_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            wr_n   = 1'b1;
                            data_n = {1'b0, hold_data};
                            cnt_n  = cnt_inc;
                            if (cnt_inc == WINDOW_N)
                                state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_frame_writer.sv
// Randomized bench for echo_frame_writer: frames are predicted from the framing rules and compared word by word.
// Honours FRAME_COUNT_EN when defined for the build.
module tb_echo_frame_writer;

    localparam int          BLANK = 4;
    localparam int          WIN   = 3;
    localparam logic [15:0] HDR   = 16'hFFFF;
    localparam int          NONE  = 1000;

    logic        SYS_CLK = 1'b0;
    logic        RST, ON, TX_START, ADC_FIN, FIFO_FULL;
    logic [15:0] ADC_DATA;
    logic        FIFO_WR, BUSY, OVERFLOW, FRAME_DONE;
    logic [15:0] FIFO_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr = 0;
    int done_cnt = 0;
    int model_frames = 0;
    logic [15:0] obs_q[$];

    echo_frame_writer #(
        .BLANK_SAMPLES(BLANK), .WINDOW_SAMPLES(WIN), .HEADER_WORD(HDR)
    ) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .ON(ON), .TX_START(TX_START),
        .ADC_FIN(ADC_FIN), .ADC_DATA(ADC_DATA), .FIFO_FULL(FIFO_FULL),
        .FIFO_WR(FIFO_WR), .FIFO_DATA(FIFO_DATA), .BUSY(BUSY),
        .OVERFLOW(OVERFLOW), .FRAME_DONE(FRAME_DONE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge SYS_CLK) begin
        cyc++;
        if (FIFO_WR) begin
            obs_q.push_back(FIFO_DATA);
            last_wr = cyc;
        end
        if (FRAME_DONE) begin
            done_cnt++;
            chk("done_latency", 32'(cyc - last_wr), 32'd1);
            chk("busy_at_done", {31'd0, BUSY}, 32'd0);
        end
    end

    task automatic pulse_tx();
        @(posedge SYS_CLK); #1 TX_START = 1'b1;
        @(posedge SYS_CLK); #1 TX_START = 1'b0;
    endtask

    // One ADC conversion; with lat set, FIFO_WR is checked cycle by cycle after the rise.
    task automatic send_sample(input logic [15:0] data, input bit lat);
        @(posedge SYS_CLK); #1;
        ADC_DATA = data;
        ADC_FIN  = 1'b1;
        if (lat) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge SYS_CLK);
                chk($sformatf("lat_wr_k%0d", k), {31'd0, FIFO_WR}, (k == 3) ? 32'd1 : 32'd0);
                if (k == 3)
                    chk("lat_data", {16'd0, FIFO_DATA}, {16'd0, {1'b0, data[15:1]}});
                if (k == 2)
                    ADC_FIN = 1'b0;
            end
        end else begin
            repeat (2) @(posedge SYS_CLK);
            #1 ADC_FIN = 1'b0;
        end
        repeat ($urandom_range(6, 3)) @(posedge SYS_CLK);
    endtask

    task automatic run_frame(input int full_at, input int on_drop_at, input int tx_again_at, input bit lat_first);
        logic [15:0] samp[$];
        logic [15:0] exp_q[$];
        int base, n_data, lim;
        bit exp_ovf, exp_done;
        obs_q.delete();
        base = done_cnt;
        for (int i = 0; i < BLANK + WIN + 1; i++)
            samp.push_back(16'($urandom));
        if (lat_first)
            samp[BLANK] = 16'hFFFF;
        pulse_tx();
        repeat (2) @(posedge SYS_CLK);
        #1;
        chk("ovf_after_start", {31'd0, OVERFLOW}, 32'd0);
        chk("busy_after_start", {31'd0, BUSY}, 32'd1);
        for (int i = 0; i < samp.size(); i++) begin
            if (i == full_at) begin
                @(posedge SYS_CLK); #1 FIFO_FULL = 1'b1;
            end
            if (i == on_drop_at) begin
                @(posedge SYS_CLK); #1 ON = 1'b0;
                @(posedge SYS_CLK); #1 ON = 1'b1;
            end
            if (i == tx_again_at)
                pulse_tx();
            send_sample(samp[i], lat_first && (i == BLANK));
        end
        repeat (8) @(posedge SYS_CLK);
        #1;
        // Reference: header (and count), then the window truncated by FIFO full or ON drop.
        exp_ovf  = 1'b0;
        exp_done = 1'b0;
        if (full_at < BLANK) begin
            exp_ovf = 1'b1;
        end else begin
            exp_q.push_back(HDR);
`ifdef FRAME_COUNT_EN
            exp_q.push_back({1'b0, 15'(model_frames)});
`endif
            lim    = ((full_at < on_drop_at) ? full_at : on_drop_at) - BLANK;
            n_data = (lim < WIN) ? lim : WIN;
            for (int j = 0; j < n_data; j++)
                exp_q.push_back({1'b0, samp[BLANK + j][15:1]});
            exp_done = (n_data == WIN);
            exp_ovf  = (full_at < on_drop_at) && (full_at - BLANK < WIN);
        end
        chk("n_words", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
            chk($sformatf("word%0d", j), {16'd0, obs_q[j]}, {16'd0, exp_q[j]});
        chk("frame_done", 32'(done_cnt - base), exp_done ? 32'd1 : 32'd0);
        chk("overflow", {31'd0, OVERFLOW}, {31'd0, exp_ovf});
        chk("busy_end", {31'd0, BUSY}, 32'd0);
        FIFO_FULL = 1'b0;
        if (exp_done)
            model_frames++;
    endtask

    task automatic reset_mid_frame();
        bit seen;
        pulse_tx();
        for (int i = 0; i < BLANK; i++)
            send_sample(16'($urandom), 1'b0);
        @(posedge SYS_CLK); #1;
        ADC_DATA = 16'hABCD;
        ADC_FIN  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge SYS_CLK);
            if (FIFO_WR && FIFO_DATA == 16'h55E6)
                seen = 1'b1;
        end
        chk("rst_pre_write", {31'd0, seen}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst_wr", {31'd0, FIFO_WR}, 32'd0);
        chk("rst_data", {16'd0, FIFO_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
        chk("rst_done", {31'd0, FRAME_DONE}, 32'd0);
        ADC_FIN = 1'b0;
        repeat (2) @(posedge SYS_CLK);
        #1 RST = 1'b0;
        model_frames = 0;
        repeat (3) @(posedge SYS_CLK);
    endtask

    initial begin
        RST = 1'b1; ON = 1'b1; TX_START = 1'b0; ADC_FIN = 1'b0;
        ADC_DATA = 16'h0000; FIFO_FULL = 1'b0;
        #1;
        chk("reset_wr", {31'd0, FIFO_WR}, 32'd0);
        chk("reset_data", {16'd0, FIFO_DATA}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_ovf", {31'd0, OVERFLOW}, 32'd0);
        chk("reset_done", {31'd0, FRAME_DONE}, 32'd0);
        repeat (3) @(posedge SYS_CLK);
        #1 RST = 1'b0;
        repeat (2) @(posedge SYS_CLK);

        run_frame(NONE, NONE, NONE, 1'b1);
        for (int f = 0; f < 4; f++)
            run_frame(NONE, NONE, NONE, 1'b0);
        run_frame(BLANK + 1, NONE, NONE, 1'b0);
        run_frame(BLANK + $urandom_range(WIN - 1, 0), NONE, NONE, 1'b0);
        run_frame(BLANK - 1, NONE, NONE, 1'b0);
        run_frame(NONE, NONE, BLANK + 1, 1'b0);
        run_frame(NONE, BLANK + 1, NONE, 1'b0);
        run_frame(NONE, NONE, NONE, 1'b0);
        reset_mid_frame();
        run_frame(NONE, NONE, NONE, 1'b0);
        run_frame(NONE, NONE, NONE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_frame_writer.md
# echo_frame_writer

Frames ADC echo samples into the sample FIFO, one frame per ultrasonic transmit burst. Sits between the ADC SPI master and the 16-bit sample FIFO on the 65 MHz domain. On each burst start it discards a blanking run of samples to skip transmitter crosstalk, writes a marker header, then writes a fixed window of scaled samples. It stops cleanly and flags overflow if the FIFO fills.

## Interface
Parameters:
- BLANK_SAMPLES, 64: ADC samples discarded after TX_START; 0 is legal and means no blanking.
- WINDOW_SAMPLES, 1024: data words written per frame; range 1..65535.
- HEADER_WORD, 16'hFFFF: frame marker word; bit 15 must be 1.

Ports:
- SYS_CLK  in  1  system clock (CLK_65); all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- ON  in  1  run enable; low forces IDLE synchronously and clears OVERFLOW.
- TX_START  in  1  single-cycle pulse at the first pulse of a transmit burst.
- ADC_FIN  in  1  ADC SPI master finish level; a rising edge means a new sample. Rising edges are at least 4 SYS_CLK cycles apart.
- ADC_DATA  in  16  ADC sample; stable while ADC_FIN is high.
- FIFO_FULL  in  1  FIFO full flag.
- FIFO_WR  out  1  FIFO write strobe; registered, one cycle per word.
- FIFO_DATA  out  16  FIFO write data; registered.
- BUSY  out  1  high in every state except IDLE.
- OVERFLOW  out  1  sticky; the last frame was aborted on FIFO full.
- FRAME_DONE  out  1  one-cycle pulse when a frame completes.

## Operation
- Edge detection: fin_q1 <= ADC_FIN; fin_q2 <= fin_q1; sample_edge = fin_q1 & ~fin_q2. ADC_DATA is captured into a holding register on that same edge.
- Data word: {1'b0, ADC_DATA[15:1]}. Bit 15 is always 0, so a data word can never equal HEADER_WORD.
- States:
  - IDLE: on TX_START, clear the 16-bit sample counter and go to BLANK, or to HEADER if BLANK_SAMPLES == 0.
  - BLANK: each sample_edge increments the counter. When the counter reaches BLANK_SAMPLES, clear it and go to HEADER.
  - HEADER: single cycle. If FIFO_FULL, abort. Otherwise issue the header write (plus the count word under FRAME_COUNT_EN) and go to CAPTURE.
  - CAPTURE: each sample_edge writes one data word and increments the counter. If FIFO_FULL on a sample_edge, drop the word and abort. After word WINDOW_SAMPLES is written, go to DONE.
  - DONE: pulse FRAME_DONE and return to IDLE.
- Abort: set OVERFLOW, go to IDLE, no FRAME_DONE. Words already written remain in the FIFO.
- OVERFLOW clears on the next accepted TX_START or when ON is low.
- TX_START outside IDLE is ignored; the running frame continues.
- TX_START while ON is low is ignored.
- ON low mid-frame: go to IDLE on the next edge; no FRAME_DONE; no further writes.
- A sample_edge in IDLE or HEADER produces no write.
- Reset values: FIFO_WR=0, FIFO_DATA=16'h0000, BUSY=0, OVERFLOW=0, FRAME_DONE=0, state IDLE, counters 0, fin_q1=fin_q2=0.

## Timing
- ADC_FIN first sampled high at edge n: sample_edge is true in cycle n+1, data is captured at edge n+2, and FIFO_WR/FIFO_DATA are valid for exactly the one cycle between edges n+2 and n+3.
- TX_START sampled at edge t with BLANK_SAMPLES=0: HEADER during t..t+1; header FIFO_WR high for the cycle after edge t+1.
- FRAME_DONE rises one cycle after the last data word's FIFO_WR.
- BUSY falls on the same edge.
- FIFO_FULL is sampled in the same cycle as the write decision.
- Throughput: at most one word per sample_edge; headers need 1 cycle (2 under FRAME_COUNT_EN).

## Configuration
- FRAME_COUNT_EN defined: after HEADER_WORD, a second header word {1'b0, frame_cnt[14:0]} is written on the following cycle.
  - FIFO_FULL in that cycle aborts the frame.
  - frame_cnt is 15 bits, increments on every FRAME_DONE, wraps 32767→0, and resets only on RST.
- FRAME_COUNT_EN undefined: single header word; no counter logic.

## Test plan
- Basic frame: BLANK_SAMPLES=4, WINDOW_SAMPLES=3, ADC_DATA=16'h1234,16'h1236,… → 4 samples dropped, then writes FFFF, 091A, 091B, …, then a FRAME_DONE pulse; BUSY low after.
- Latency: ADC_FIN rises while in CAPTURE → FIFO_WR high exactly 2 edges later, for 1 cycle; ADC_DATA=16'hFFFF → FIFO_DATA=16'h7FFF.
- Overflow: FIFO_FULL forced high before the 2nd data word → exactly 2 writes (header and 1st data word), OVERFLOW=1, no FRAME_DONE, BUSY=0. Next TX_START clears OVERFLOW.
- Ignored trigger: TX_START mid-CAPTURE → frame length unchanged (1+WINDOW_SAMPLES writes); no restart.
- Reset and ON: RST asserted mid-frame → all outputs 0 immediately (asynchronously); ON low mid-frame → no further writes, no FRAME_DONE.
- FRAME_COUNT_EN: three frames → second header word values 0000, 0001, 0002.
